// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional-N sigma-delta clock divider.
// Holds the state enum, the FBITS default, configuration decode and parameter legality check.
package frac_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FBITS_DEF = 3;

  // Integer part of the period: N plus the floor of the signed offset mf, modulo 2^width.
  function automatic logic [63:0] coarse_of(input logic [63:0] n, input logic [63:0] mf,
                                            input int width, input int fbits);
    logic [63:0] mf_int;
    logic [63:0] mask;
    mf_int = $signed(mf << (64 - width)) >>> (64 - width + fbits);
    mask   = (64'd1 << width) - 64'd1;
    return (n + mf_int) & mask;
  endfunction

  function automatic bit params_legal(input int width, input int fbits);
    return (fbits >= 1) && (fbits <= 8) && (width > fbits + 1) && (width <= 64);
  endfunction

endpackage

// File: rtl/frac_divider_sd_if.sv
// Configuration and status bundle of the fractional-N divider.
// master drives configuration and enable; slave is the divider itself.
interface frac_divider_sd_if #(parameter int WIDTH = 17);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] mf;
  logic [WIDTH-1:0] count;
  logic             q_out;
  logic             tc;
  logic             cfg_err;

  modport master (output en, load, N, mf, input count, q_out, tc, cfg_err);
  modport slave  (input en, load, N, mf, output count, q_out, tc, cfg_err);
endinterface

// File: rtl/frac_sd_acc.sv
// First-order sigma-delta phase accumulator; carry stretches the current period by one cycle.
// acc advances only on step, so its phase survives enable gaps and reprogramming.
module frac_sd_acc
  import frac_div_pkg::*;
#(
  parameter int FBITS = FBITS_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             step,
  input  logic [FBITS-1:0] frac,
  output logic             carry
);

  logic [FBITS-1:0] acc;
  logic [FBITS:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FBITS];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FBITS-1:0];
    end
  end

endmodule

// File: rtl/frac_divider_sd.sv
// Fractional-N clock divider: periods of coarse or coarse+1 cycles chosen by a sigma-delta
// accumulator, with double-buffered configuration applied only at period boundaries.
module frac_divider_sd
  import frac_div_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int FBITS = FBITS_DEF
) (
  input logic               sys_clk,
  input logic               rst,
  frac_divider_sd_if.slave  bus
);

  if (!params_legal(WIDTH, FBITS)) begin : g_param_check
    $error("frac_divider_sd: illegal WIDTH/FBITS combination");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] coarse_in, act_coarse, pend_coarse, sel_coarse;
  logic [FBITS-1:0] frac_in, act_frac, pend_frac, sel_frac;
  logic [WIDTH-1:0] count_r, half_r;
  logic [WIDTH:0]   period;
  logic             pend_flag, load_ok, load_acc, start, carry;
  logic             q_r, tc_r, err_r;

  assign coarse_in = WIDTH'(coarse_of(64'(bus.N), 64'(bus.mf), WIDTH, FBITS));
  assign frac_in   = bus.mf[FBITS-1:0];
  assign load_ok   = coarse_in >= WIDTH'(2);
  assign load_acc  = bus.load && load_ok;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A load accepted on a boundary cycle (IDLE start or tc) governs the period it starts.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    sel_coarse = act_coarse;
    sel_frac   = act_frac;
    if (load_acc) begin
      sel_coarse = coarse_in;
      sel_frac   = frac_in;
    end else if (pend_flag) begin
      sel_coarse = pend_coarse;
      sel_frac   = pend_frac;
    end
    case (state)
      IDLE: begin
        if (load_acc && bus.en) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (bus.en && count_r == '0) start = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  frac_sd_acc #(.FBITS(FBITS)) u_acc (
    .sys_clk (sys_clk),
    .rst     (rst),
    .step    (start),
    .frac    (sel_frac),
    .carry   (carry)
  );

  assign period = {1'b0, sel_coarse} + (WIDTH + 1)'(carry);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      act_coarse  <= '0;
      act_frac    <= '0;
      pend_coarse <= '0;
      pend_frac   <= '0;
      pend_flag   <= 1'b0;
      count_r     <= '0;
      half_r      <= '0;
      q_r         <= 1'b0;
      tc_r        <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (bus.load) err_r <= !load_ok;
      if (start) begin
        act_coarse <= sel_coarse;
        act_frac   <= sel_frac;
        pend_flag  <= 1'b0;
        count_r    <= WIDTH'(period - 1'b1);
        half_r     <= WIDTH'(period >> 1);
        // coarse >= 2 guarantees D-1 >= D/2, so every period opens high
        q_r        <= 1'b1;
        tc_r       <= 1'b0;
      end else begin
        if (load_acc) begin
          pend_coarse <= coarse_in;
          pend_frac   <= frac_in;
          pend_flag   <= 1'b1;
        end
        if (state == RUN && bus.en) begin
          count_r <= count_r - 1'b1;
          q_r     <= (count_r - 1'b1) >= half_r;
          tc_r    <= count_r == WIDTH'(1);
        end
      end
    end
  end

  assign bus.count   = count_r;
  assign bus.q_out   = q_r;
  assign bus.tc      = tc_r && bus.en;
  assign bus.cfg_err = err_r;

endmodule

// File: tb/tb_frac_divider_sd.sv
// Self-checking bench for frac_divider_sd: expected period lengths and high-phase widths
// are queued as stimulus is applied and compared as each terminal count arrives.
module tb_frac_divider_sd;
  import frac_div_pkg::*;

  localparam int WIDTH = 17;
  localparam int FBITS = 3;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;

  frac_divider_sd_if #(.WIDTH(WIDTH)) bus ();

  frac_divider_sd #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int len;
    int hi;
  } period_t;

  period_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int since_tc, hi_cnt, last_len, last_hi, tc_total, m_acc;
  bit tc_seen;

  task automatic tick();
    @(negedge sys_clk);
    since_tc++;
    if (bus.q_out) hi_cnt++;
    if (bus.tc) begin
      last_len = since_tc;
      last_hi  = hi_cnt;
      since_tc = 0;
      hi_cnt   = 0;
      tc_seen  = 1'b1;
      tc_total++;
    end
  endtask

  task automatic wait_tc(output bit ok);
    tc_seen = 1'b0;
    for (int i = 0; i < 300 && !tc_seen; i++) tick();
    ok = tc_seen;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
    bus.N    = n;
    bus.mf   = m;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic do_reset();
    bus.en   = 1'b1;
    bus.load = 1'b0;
    bus.N    = '0;
    bus.mf   = '0;
    rst      = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    since_tc = 0;
    hi_cnt   = 0;
    tc_total = 0;
    m_acc    = 0;
    exp_q.delete();
  endtask

  // Reference sigma-delta: 2^FBITS = 8 phase steps per wrap.
  function automatic void push_model(input int coarse, input int frac, input int n);
    for (int i = 0; i < n; i++) begin
      int s, d;
      s     = m_acc + frac;
      m_acc = s % 8;
      d     = coarse + ((s >= 8) ? 1 : 0);
      exp_q.push_back('{d, d - d / 2});
    end
  endfunction

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL reset_count: got %0d need 0", bus.count); end
    n_cmp++; if (bus.q_out !== 1'b0) begin n_err++; $display("FAIL reset_q_out: got %b need 0", bus.q_out); end
    n_cmp++; if (bus.tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b need 0", bus.tc); end
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b need 0", bus.cfg_err); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL idle_count: got %0d need 0", bus.count); end
    n_cmp++; if (tc_total !== 0) begin n_err++; $display("FAIL idle_tc: got %0d tc pulses need 0", tc_total); end
  endtask

  task automatic test_positive();
    bit ok;
    period_t e;
    int sum;
    int pat[9] = '{10, 10, 11, 10, 10, 11, 10, 11, 10};
    do_reset();
    since_tc = 0; hi_cnt = 0;
    do_load(17'd10, 17'd3);
    n_cmp++; if (bus.count !== 17'd9) begin n_err++; $display("FAIL pos_first_count: got %0d need 9", bus.count); end
    n_cmp++; if (bus.q_out !== 1'b1) begin n_err++; $display("FAIL pos_first_q_out: got %b need 1", bus.q_out); end
    foreach (pat[i]) exp_q.push_back('{pat[i], pat[i] - pat[i] / 2});
    sum = 0;
    for (int i = 0; i < 9; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      if (i > 0) sum += last_len;
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL pos_period[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
    n_cmp++; if (sum !== 83) begin n_err++; $display("FAIL pos_8_period_sum: got %0d need 83", sum); end
  endtask

  task automatic test_negative();
    bit ok;
    period_t e;
    int sum;
    do_reset();
    since_tc = 0; hi_cnt = 0;
    do_load(17'd10, 17'h1FFFD);
    push_model(9, 5, 8);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      sum += last_len;
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL neg_period[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
    n_cmp++; if (sum !== 77) begin n_err++; $display("FAIL neg_8_period_sum: got %0d need 77", sum); end
  endtask

  task automatic test_reprogram();
    bit ok;
    period_t e;
    do_reset();
    since_tc = 0; hi_cnt = 0;
    do_load(17'd8, 17'd0);
    exp_q.push_back('{8, 4});
    wait_tc(ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || last_len !== e.len) begin n_err++; $display("FAIL rp_start: got len=%0d timeout=%0b need %0d", last_len, !ok, e.len); end
    // load lands on the tc cycle: takes effect immediately
    do_load(17'd6, 17'd0);
    exp_q.push_back('{6, 3}); exp_q.push_back('{6, 3});
    for (int i = 0; i < 2; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL rp_coincident[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
    tick(); tick();
    do_load(17'd8, 17'd0);
    exp_q.push_back('{6, 3}); exp_q.push_back('{8, 4});
    tick();
    do_load(17'd0, 17'd0);
    // rejected load above must not disturb the pending 8; then two loads, last one wins
    for (int i = 0; i < 2; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL rp_mid[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
    tick();
    do_load(17'd5, 17'd0);
    tick();
    do_load(17'd7, 17'd0);
    exp_q.push_back('{8, 4}); exp_q.push_back('{7, 4});
    for (int i = 0; i < 2; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL rp_overwrite[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
  endtask

  task automatic test_reject();
    bit ok;
    period_t e;
    tick(); tick();
    do_load(17'd1, 17'd0);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_err++; $display("FAIL rej_n1_err: got %b need 1", bus.cfg_err); end
    exp_q.push_back('{7, 4}); exp_q.push_back('{7, 4});
    for (int i = 0; i < 2; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL rej_keep[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
    tick();
    do_load(17'd3, 17'h1FFF8);
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_err++; $display("FAIL rej_clear_err: got %b need 0", bus.cfg_err); end
    tick();
    do_load(17'd2, 17'h1FFF8);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_err++; $display("FAIL rej_coarse1_err: got %b need 1", bus.cfg_err); end
    exp_q.push_back('{7, 4}); exp_q.push_back('{2, 1}); exp_q.push_back('{2, 1});
    for (int i = 0; i < 3; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL rej_boundary[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
  endtask

  task automatic test_en_gating();
    bit ok;
    period_t e;
    int tc_before;
    do_reset();
    since_tc = 0; hi_cnt = 0;
    do_load(17'd10, 17'd3);
    push_model(10, 3, 1);
    wait_tc(ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || last_len !== e.len) begin n_err++; $display("FAIL en_first: got len=%0d timeout=%0b need %0d", last_len, !ok, e.len); end
    tick(); tick(); tick();
    n_cmp++; if (bus.count !== 17'd7) begin n_err++; $display("FAIL en_pre_count: got %0d need 7", bus.count); end
    bus.en = 1'b0;
    tc_before = tc_total;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.count !== 17'd7 || bus.q_out !== 1'b1) begin
        n_err++;
        $display("FAIL en_frozen[%0d]: got count=%0d q_out=%b need count=7 q_out=1", i, bus.count, bus.q_out);
      end
    end
    n_cmp++; if (tc_total !== tc_before) begin n_err++; $display("FAIL en_tc_low: got %0d pulses need 0", tc_total - tc_before); end
    bus.en = 1'b1;
    push_model(10, 3, 4);
    exp_q[0].len += 5;
    exp_q[0].hi  += 5;
    for (int i = 0; i < 4; i++) begin
      wait_tc(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || last_len !== e.len || last_hi !== e.hi) begin
        n_err++;
        $display("FAIL en_period[%0d]: got len=%0d hi=%0d timeout=%0b need len=%0d hi=%0d", i, last_len, last_hi, !ok, e.len, e.hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int tc_before;
    do_reset();
    do_load(17'd8, 17'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.count == 17'd4) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rst_mid_reach: count 4 not seen, got %0d", bus.count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL rst_mid_count: got %0d need 0", bus.count); end
    n_cmp++; if (bus.q_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_q_out: got %b need 0", bus.q_out); end
    n_cmp++; if (bus.tc !== 1'b0) begin n_err++; $display("FAIL rst_mid_tc: got %b need 0", bus.tc); end
    tick();
    rst = 1'b0;
    tc_before = tc_total;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL rst_mid_idle_count: got %0d need 0", bus.count); end
    n_cmp++; if (tc_total !== tc_before) begin n_err++; $display("FAIL rst_mid_idle_tc: got %0d pulses need 0", tc_total - tc_before); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_reprogram();
    test_reject();
    test_en_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
